div_8by4: RTL

- Sequential restoring divider: 8-bit dividend by 4-bit divisor, producing an 8-bit quotient and a 4-bit remainder.
- Inverse counterpart of the 4x4 sequential multiplier core. Uses the same init/done handshake so the two cores are interchangeable behind a TinyTapeout wrapper: operands on ui_in/uio_in, result on uo_out, init/done on uio pins.
- Can verify the multiplier: dividing a product by one factor must return the other factor with remainder 0.

---
 rtl/div_8by4.sv | 103 ++++++++++
 1 files changed

// File: rtl/div_8by4.sv
// Sequential restoring divider: DVW-bit dividend by DSW-bit divisor, one quotient
// bit per SHIFT/SUB pair, with an init/done handshake shared with the multiplier core.
module div_8by4 #(
  parameter int unsigned DVW = 8,
  parameter int unsigned DSW = 4,
  parameter int unsigned CW  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init,
  input  logic [DVW-1:0] DV,
  input  logic [DSW-1:0] DS,
  output logic [DVW-1:0] Q,
  output logic [DSW-1:0] R,
  output logic           done,
  output logic           dz
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [DSW:0]   rem;
  logic [DVW-1:0] quot;
  logic [DSW-1:0] dsreg;
  logic [CW-1:0]  cnt;

  logic           sub_ok_c;
  logic [DSW:0]   rem_nx_c;
  logic [DVW-1:0] quot_nx_c;

  // Trial subtraction; the extra remainder bit absorbs the bit shifted in.
  always_comb begin
    sub_ok_c  = (rem >= {1'b0, dsreg});
    rem_nx_c  = sub_ok_c ? (rem - {1'b0, dsreg}) : rem;
    quot_nx_c = {quot[DVW-1:1], sub_ok_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (init) state_nx = (DS == '0) ? DONE : SHIFT;
      SHIFT:   state_nx = SUB;
      SUB:     state_nx = (cnt == CW'(1)) ? DONE : SHIFT;
      DONE:    if (!init) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs; Q/R/dz only move on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      quot  <= '0;
      dsreg <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (init) begin
            dsreg <= DS;
            if (DS == '0) begin
              Q  <= '1;
              R  <= '1;
              dz <= 1'b1;
            end else begin
              quot <= DV;
              rem  <= '0;
              cnt  <= CW'(DVW);
            end
          end
        end
        SHIFT: {rem, quot} <= {rem, quot} << 1;
        SUB: begin
          rem  <= rem_nx_c;
          quot <= quot_nx_c;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            Q  <= quot_nx_c;
            R  <= rem_nx_c[DSW-1:0];
            dz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
